// File: rtl/seg4x7_scroller_pkg.sv
// Shared types and constants for the ASCII seven-segment scroller.
// No logic; imported by the scroller and its sub-modules.
package seg4x7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SCROLL = 2'd2
   } state_t;

   localparam logic [7:0]  ASCII_SPACE = 8'h20;
   localparam logic [7:0]  ASCII_LF    = 8'h0A;
   localparam logic [31:0] BLANK_WORD  = 32'h20202020;

endpackage

// File: rtl/seg4x7_scroller_if.sv
// Byte-stream handshake into the scroller (valid/ready).
// The producer drives data/valid; the scroller drives ready.
interface seg4x7_scroller_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seg4x7_tick.sv
// Scroll-rate prescaler: one-cycle tick every SCROLL_DIV cycles, sync clear.
// Latency: first tick SCROLL_DIV-1 cycles after clr drops; no backpressure.
// clr holds the count at zero and suppresses the tick.
module seg4x7_tick #(
   parameter int SCROLL_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CNTW = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [CNTW-1:0] TERM = CNTW'(SCROLL_DIV - 1);

   logic [CNTW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || cnt_q == TERM) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNTW'(1);
      end
   end

   assign tick = !clr && (cnt_q == TERM);
endmodule

// File: rtl/seg4x7_scroller.sv
// Stores one ASCII message and presents a scrolling 4-char window (gap: SEG4X7_SCROLL_GAP_EN).
// Latency: an accepted byte is reflected in text/state one cycle later.
// Backpressure: none; in_ready is 1 from the first clock after reset release.
module seg4x7_scroller
   import seg4x7_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int SCROLL_DIV = 25_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   seg4x7_scroller_if.slave in_if,
   output logic [31:0]      text,
   output logic             scrolling
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(DEPTH + 4);
   localparam int CW = PW + 1;
`ifdef SEG4X7_SCROLL_GAP_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 0;
`endif
   localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1);

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [31:0]     text_q, text_d;
   logic            rdy_q;
   logic            acc, is_lf, wr_en, tick, tick_clr;
   logic [AW-1:0]   wr_idx;
   logic [7:0]      mem [DEPTH];
   logic [CW-1:0]   per_q, per_d, pos_inc;
   logic [CW-1:0]   sidx [4];
   logic [7:0]      rd_chr [4];

   assign in_if.in_ready = rdy_q;
   assign acc       = in_if.in_valid && rdy_q;
   assign is_lf     = (in_if.in_data == ASCII_LF);
   assign text      = text_q;
   assign scrolling = (state_q == ST_SCROLL);
   assign tick_clr  = (state_q != ST_SCROLL);
   assign per_q     = CW'(len_q) + CW'(GAP);
   assign pos_inc   = CW'(pos_q) + CW'(1);

   seg4x7_tick #(.SCROLL_DIV(SCROLL_DIV)) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      pos_d   = pos_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      case (state_q)
         ST_IDLE: begin
            if (acc && !is_lf) begin
               wr_en   = 1'b1;
               len_d   = LEN_ONE;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (acc) begin
               if (is_lf) begin
                  state_d = ST_SCROLL;
                  pos_d   = '0;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = len_q[AW-1:0];
                  len_d  = len_q + LEN_ONE;
                  if (len_q + LEN_ONE == LEN_FULL) begin
                     state_d = ST_SCROLL;
                     pos_d   = '0;
                  end
               end
            end
         end
         ST_SCROLL: begin
            // Any accepted byte swallows a coincident tick; LF is otherwise ignored.
            if (acc) begin
               if (!is_lf) begin
                  wr_en   = 1'b1;
                  len_d   = LEN_ONE;
                  state_d = ST_LOAD;
               end
            end else if (tick) begin
               pos_d = (pos_inc >= per_q) ? '0 : pos_inc[PW-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Window indices for the next state; the byte being written is forwarded
   // so an overflow-terminated message shows its last character immediately.
   always_comb begin
      logic [CW-1:0] nx;
      logic [AW-1:0] j;
      per_d   = CW'(len_d) + CW'(GAP);
      sidx[0] = CW'(pos_d);
      for (int k = 1; k < 4; k++) begin
         nx      = sidx[k-1] + CW'(1);
         sidx[k] = (nx >= per_d) ? nx - per_d : nx;
      end
      for (int k = 0; k < 4; k++) begin
         j = sidx[k][AW-1:0];
         if (sidx[k] < CW'(len_d)) begin
            rd_chr[k] = (wr_en && wr_idx == j) ? in_if.in_data : mem[j];
         end else begin
            rd_chr[k] = ASCII_SPACE;
         end
      end
   end

   always_comb begin
      text_d = BLANK_WORD;
      case (state_d)
         ST_IDLE: text_d = BLANK_WORD;
         ST_LOAD: begin
            if (wr_en) begin
               text_d = {(state_q == ST_LOAD) ? text_q[23:0] : BLANK_WORD[23:0],
                         in_if.in_data};
            end else begin
               text_d = text_q;
            end
         end
         ST_SCROLL: text_d = {rd_chr[0], rd_chr[1], rd_chr[2], rd_chr[3]};
         default:   text_d = BLANK_WORD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         pos_q   <= '0;
         text_q  <= BLANK_WORD;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         pos_q   <= pos_d;
         text_q  <= text_d;
         rdy_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= in_if.in_data;
      end
   end
endmodule

// File: tb/tb_seg4x7_scroller.sv
// Bench for seg4x7_scroller: directed steps plus random bytes against a message-level model.
module tb_seg4x7_scroller;
   localparam int DEPTH = 8;
   localparam int DIV   = 4;
`ifdef SEG4X7_SCROLL_GAP_EN
   localparam int GAP = 4;
`else
   localparam int GAP = 0;
`endif
   localparam logic [7:0]  LF    = 8'h0A;
   localparam logic [31:0] BLANK = 32'h20202020;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] text;
   logic        scrolling;

   seg4x7_scroller_if bus ();

   seg4x7_scroller #(.DEPTH(DEPTH), .SCROLL_DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_if    (bus),
      .text     (text),
      .scrolling(scrolling)
   );

   always #5 clk = ~clk;

   // Model: mode 0=idle, 1=loading, 2=scrolling; message kept as a queue.
   int         mode;
   logic [7:0] msg[$];
   int         pos;
   int         cyc;
   int         checks   = 0;
   int         failures = 0;

   function automatic logic [31:0] exp_text();
      logic [31:0] w = BLANK;
      int n = msg.size();
      int p = n + GAP;
      for (int k = 0; k < 4; k++) begin
         int j;
         if (mode == 1) begin
            j = n - 4 + k;
            if (j >= 0) w[31-8*k -: 8] = msg[j];
         end else if (mode == 2) begin
            j = (pos + k) % p;
            if (j < n) w[31-8*k -: 8] = msg[j];
         end
      end
      return w;
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d);
      if (mode == 0) begin
         if (v && d != LF) begin
            msg = {d};
            mode = 1;
         end
      end else if (mode == 1) begin
         if (v) begin
            if (d == LF) begin
               mode = 2; pos = 0; cyc = 0;
            end else begin
               msg.push_back(d);
               if (msg.size() == DEPTH) begin
                  mode = 2; pos = 0; cyc = 0;
               end
            end
         end
      end else begin
         bit tk;
         cyc = cyc + 1;
         tk = (cyc == DIV);
         if (tk) cyc = 0;
         if (v) begin
            if (d != LF) begin
               msg = {d};
               mode = 1;
            end
         end else if (tk) begin
            pos = (pos + 1) % (msg.size() + GAP);
         end
      end
   endtask

   task automatic model_reset();
      mode = 0; msg.delete(); pos = 0; cyc = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_text"}, text, exp_text());
      check({tag, "_scrolling"}, {31'b0, scrolling}, {31'b0, mode == 2});
      check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
   endtask

   task automatic step(input logic v, input logic [7:0] d, input string tag);
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic send_str(input string s, input string tag);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i], tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_text"}, text, BLANK);
      check({tag, "_scrolling"}, {31'b0, scrolling}, 32'd0);
      check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst_n = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(1, "release");

      // LF in IDLE is ignored
      step(1'b1, LF, "idle_lf");
      check("idle_lf_const", text, BLANK);

      // Load and echo
      send_str("AB", "echo");
      check("echo_AB", text, 32'h20204142);
      send_str("CDE", "echo");
      check("echo_E", text, 32'h42434445);
      check("echo_noscroll", {31'b0, scrolling}, 32'd0);
      step(1'b1, LF, "term5");
      idle(6, "scroll5");

      // Restart from SCROLL with "HI", terminate, watch a full period
      send_str("HI", "hi_load");
      step(1'b1, LF, "hi_term");
      check("hi_first", text, (GAP != 0) ? 32'h48492020 : 32'h48494849);
      check("hi_scrolling", {31'b0, scrolling}, 32'd1);
      idle(4, "hi_run");
      check("hi_step1", text, (GAP != 0) ? 32'h49202020 : 32'h49484948);
      idle(20, "hi_run");
      check("hi_wrap", text, (GAP != 0) ? 32'h48492020 : 32'h48494849);

      // Byte accepted on the same cycle as a tick: restart wins
      for (int i = 0; i < DIV && cyc != DIV - 1; i++) idle(1, "align");
      check("align_to_tick", cyc, DIV - 1);
      step(1'b1, "Z", "restart_tick");
      check("restart_text", text, 32'h2020205A);
      check("restart_load", {31'b0, scrolling}, 32'd0);

      // Overflow ends LOAD without a LF
      step(1'b1, LF, "z_term");
      idle(3, "z_scroll");
      send_str("01234567", "ovf");
      check("ovf_scrolling", {31'b0, scrolling}, 32'd1);
      check("ovf_text", text, 32'h30313233);
      idle(9, "ovf_scroll");

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic       v;
         logic [7:0] d;
         v = ($urandom_range(0, 99) < 25);
         d = ($urandom_range(0, 4) == 0) ? LF : 8'(8'h41 + $urandom_range(0, 25));
         step(v, d, "rand");
      end

      // Async reset mid-scroll
      send_str("OK", "ar_load");
      step(1'b1, LF, "ar_term");
      idle(5, "ar_scroll");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1, "rerelease");
      send_str("Q", "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
